mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Parametrised iterative multiply/divide engine feeding the Hi/Lo registers of the multicycle CPU.
//  Replaces the separate mult and div blocks with one shared datapath.
//  Adds signed and unsigned modes, a start/busy/done handshake and a divide-by-zero flag.
//  The flag drives the control unit's exception path.
// PARAMETERS
//  WIDTH     32  operand width; hi/lo are WIDTH each; iteration count = WIDTH
//  CNT_W     6   iteration counter width, must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk       in   1      system clock, all state on rising edge
//  reset     in   1      synchronous, active-low; sampled on rising clk
//  start     in   1      request; accepted only in IDLE
//  op        in   2      00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU; sampled with start
//  a         in   WIDTH  multiplicand / dividend; sampled with start
//  b         in   WIDTH  multiplier / divisor; sampled with start
//  busy      out  1      high from the cycle after accept until done
//  done      out  1      one-cycle pulse; hi/lo/div_zero valid from this cycle
//  hi        out  WIDTH  MULT: upper product half; DIV: remainder
//  lo        out  WIDTH  MULT: lower product half; DIV: quotient
//  div_zero  out  1      set with done when DIV/DIVU has b==0; cleared on next accept
// BEHAVIOUR
//  Reset (reset==0 at an edge): state=IDLE; busy, done, div_zero = 0; hi, lo = 0; counter = 0.
//    Reset aborts any operation in flight; no done is produced.
//  FSM states: IDLE -> RUN -> FIX -> DONE -> IDLE. Encoding is in the package.
//  IDLE: on start==1, latch op, |a|, |b| and the result signs (signed ops only). Clear div_zero.
//    DIV with b==0: go straight to DONE and set div_zero. hi/lo hold their previous values.
//    Otherwise load counter=WIDTH and go to RUN.
//  RUN: one radix-2 step per cycle; counter decrements and leaves RUN when it reaches 0.
//    MULT: shift-add over a 2*WIDTH accumulator.
//    DIV: restoring shift-subtract; remainder register is WIDTH+1 bits wide.
//  FIX: apply two's-complement negation where the result sign is negative.
//    Signed MULT: product negated if a[MSB]^b[MSB].
//    Signed DIV: quotient truncates toward zero; remainder takes the dividend's sign.
//    DIV of MIN by -1: lo=MIN, hi=0 (wraps), div_zero stays 0.
//  DONE: register hi/lo, pulse done for one cycle, return to IDLE.
//  Latency, start sampled at edge k:
//    normal ops: done high after edge k+WIDTH+2 (34 cycles for WIDTH=32)
//    divide-by-zero: done high after edge k+1
//  busy=1 in RUN and FIX. start while busy or in DONE is ignored and never queued.
//  start in the same cycle reset==0: reset wins.
//  A new start may be accepted in the cycle after done; hi/lo hold until the next DONE.
//  All arithmetic is modulo 2**WIDTH except the internal 2*WIDTH product and the WIDTH+1 remainder.
// STRUCTURE
//  Package md_pkg holds:
//    op codes OP_MULT/OP_MULTU/OP_DIV/OP_DIVU
//    FSM state localparams S_IDLE/S_RUN/S_FIX/S_DONE
//  Sub-module md_sign_cond(WIDTH) conditions operands and results.
//    Combinational abs/negate: inputs value and neg; output the conditioned value.
//    Instantiated for each operand and each result.
//  The iteration datapath and the FSM stay in mult_div_unit.
// TESTING (WIDTH=32)
//  1 MULT a=FFFFFFFD(-3) b=00000007 -> done at edge k+34; hi=FFFFFFFF lo=FFFFFFEB; div_zero=0
//  2 MULTU a=b=FFFFFFFF -> hi=FFFFFFFE lo=00000001
//  3 DIV a=FFFFFFF9(-7) b=00000002 -> lo=FFFFFFFD(-3) hi=FFFFFFFF(-1); DIVU 100/7 -> lo=0000000E hi=00000002
//  4 DIVU a=64 b=0 after test 3 -> done at k+1; div_zero=1; hi/lo unchanged; next accept clears div_zero
//  5 DIV a=80000000 b=FFFFFFFF -> lo=80000000 hi=00000000 div_zero=0
//  6 start pulses at k+5 and k+33 during busy -> ignored, exactly one done;
//    reset=0 at k+10 of a new op -> busy=0, hi=lo=0, no done

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg: op codes and FSM state encoding shared by the multiply/divide engine
package md_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/md_sign_cond.sv
// md_sign_cond: two's-complement abs/negate conditioner for operands and results
module md_sign_cond #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             neg,
    output logic [WIDTH-1:0] result
);

    assign result = neg ? ~value + 1'b1 : value;

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: shared iterative signed/unsigned multiply-divide engine for Hi/Lo
module mult_div_unit
    import md_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    state_t               state, state_nx;
    logic [CNT_W-1:0]     cnt;
    logic                 is_div, neg_q, neg_r, dz_pend;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH:0]       rem;

    logic                 signed_op, b_zero;
    logic [WIDTH-1:0]     a_abs, b_abs, quot_c, rem_c;
    logic [2*WIDTH-1:0]   prod_c;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH+1:0]     div_sh, div_diff;
    logic                 div_ge;

    assign signed_op = ~op[0];
    assign b_zero    = op[1] && (b == '0);
    assign busy      = (state == S_RUN) || (state == S_FIX);

    md_sign_cond #(.WIDTH(WIDTH)) u_abs_a (
        .value (a),
        .neg   (signed_op & a[WIDTH-1]),
        .result(a_abs)
    );

    md_sign_cond #(.WIDTH(WIDTH)) u_abs_b (
        .value (b),
        .neg   (signed_op & b[WIDTH-1]),
        .result(b_abs)
    );

    md_sign_cond #(.WIDTH(2*WIDTH)) u_fix_prod (
        .value (acc),
        .neg   (neg_q),
        .result(prod_c)
    );

    md_sign_cond #(.WIDTH(WIDTH)) u_fix_quot (
        .value (acc[WIDTH-1:0]),
        .neg   (neg_q),
        .result(quot_c)
    );

    md_sign_cond #(.WIDTH(WIDTH)) u_fix_rem (
        .value (rem[WIDTH-1:0]),
        .neg   (neg_r),
        .result(rem_c)
    );

    // one radix-2 step: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? mag_a : '0};
        div_sh   = {rem, acc[WIDTH-1]};
        div_diff = div_sh - {2'b00, mag_b};
        div_ge   = ~div_diff[WIDTH+1];
    end

    // state register
    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    // next-state: divide-by-zero skips straight to DONE, otherwise WIDTH steps then sign fix
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = b_zero ? S_DONE : S_RUN;
            S_RUN:   if (cnt == CNT_W'(1)) state_nx = S_FIX;
            S_FIX:   state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // datapath: latch magnitudes on accept, iterate, apply signs, publish hi/lo
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz_pend  <= 1'b0;
            mag_a    <= '0;
            mag_b    <= '0;
            acc      <= '0;
            rem      <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= (state == S_DONE);
            case (state)
                S_IDLE: if (start) begin
                    is_div   <= op[1];
                    neg_q    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_r    <= signed_op & a[WIDTH-1];
                    dz_pend  <= b_zero;
                    mag_a    <= a_abs;
                    mag_b    <= b_abs;
                    acc      <= {{WIDTH{1'b0}}, op[1] ? a_abs : b_abs};
                    rem      <= '0;
                    cnt      <= CNT_W'(WIDTH);
                    div_zero <= 1'b0;
                end
                S_RUN: begin
                    cnt <= cnt - 1'b1;
                    if (is_div) begin
                        rem              <= div_ge ? div_diff[WIDTH:0] : div_sh[WIDTH:0];
                        acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], div_ge};
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                end
                S_FIX: acc <= is_div ? {rem_c, quot_c} : prod_c;
                S_DONE: begin
                    div_zero <= dz_pend;
                    if (!dz_pend) begin
                        hi <= acc[2*WIDTH-1:WIDTH];
                        lo <= acc[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized scoreboard bench for the multiply/divide engine
module tb_mult_div_unit;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0, failures = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int k);
        exp_t               e;
        logic signed [63:0] sx, sy;
        logic [63:0]        p;
        longint             q, r;
        e.hi  = m_hi;
        e.lo  = m_lo;
        e.dz  = 1'b0;
        e.due = k + 34;
        sx = $signed({{32{x[31]}}, x});
        sy = $signed({{32{y[31]}}, y});
        if (o[1] && y == 0) begin
            e.dz  = 1'b1;
            e.due = k + 1;
        end else if (o == OP_MULT) begin
            p = sx * sy;
            {e.hi, e.lo} = p;
        end else if (o == OP_MULTU) begin
            p = {32'b0, x} * {32'b0, y};
            {e.hi, e.lo} = p;
        end else if (o == OP_DIV) begin
            q = longint'(sx) / longint'(sy);
            r = longint'(sx) % longint'(sy);
            p = q;
            e.lo = p[31:0];
            p = r;
            e.hi = p[31:0];
        end else begin
            e.lo = x / y;
            e.hi = x % y;
        end
        return e;
    endfunction

    // called at a negedge; the following posedge is the accept edge
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        e = model(o, x, y, cyc + 1);
        op = o; a = x; b = y; start = 1'b1;
        sb.push_back(e);
        if (!e.dz) begin
            m_hi = e.hi;
            m_lo = e.lo;
        end
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", busy, !e.dz);
        chk("div_zero_cleared_on_accept", div_zero, 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=no_done expected=done (cycle %0d)", cyc);
            sb.delete();
        end
    endtask

    // monitor: every done pulse is matched against the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (reset && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=done expected=no_done (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("hi", hi, e.hi);
                chk("lo", lo, e.lo);
                chk("div_zero", div_zero, e.dz);
                chk("done_cycle", cyc, e.due);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  ro;
        logic [31:0] rx, ry;
        int          sel;

        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_div_zero", div_zero, 0);
        reset = 1'b1;
        @(negedge clk);

        issue(OP_MULT,  32'hFFFFFFFD, 32'h00000007); wait_done();
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF); wait_done();
        issue(OP_DIV,   32'hFFFFFFF9, 32'h00000002); wait_done();
        issue(OP_DIVU,  32'd100,      32'd7);        wait_done();
        issue(OP_DIVU,  32'h00000064, 32'h00000000); wait_done();
        issue(OP_DIV,   32'h80000000, 32'hFFFFFFFF); wait_done();
        issue(OP_DIV,   32'h00000005, 32'h00000000); wait_done();
        issue(OP_MULT,  32'h80000000, 32'h80000000); wait_done();

        // starts while busy must be ignored: exactly one done for this op
        issue(OP_MULTU, 32'd12345, 32'd6789);
        repeat (4) @(negedge clk);
        op = OP_DIVU; a = 32'd1; b = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (27) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (40) @(negedge clk);

        // reset in flight aborts the op with no done
        issue(OP_MULT, 32'd7, 32'd9);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        repeat (40) @(negedge clk);

        // reset wins over a simultaneous start
        reset = 1'b0; start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd3;
        @(negedge clk);
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        chk("reset_beats_start_busy", busy, 0);
        repeat (3) @(negedge clk);

        issue(OP_DIVU, 32'd64, 32'd0); wait_done();

        for (int i = 0; i < 40; i++) begin
            ro  = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 9);
            rx  = (sel == 3) ? 32'h80000000 : $urandom;
            ry  = (sel == 0) ? 32'd0 :
                  (sel == 1) ? 32'($urandom_range(1, 15)) :
                  (sel == 2) ? 32'hFFFFFFFF : $urandom;
            issue(ro, rx, ry);
            wait_done();
        end

        repeat (5) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drained actual=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
